// File: rtl/ysyx_23060072_pkg.sv
// Shared types and defaults for the ysyx_23060072 memory arbiter.
// Holds the arbiter FSM state encoding, the requester grant encoding
// and the default address/data widths used by the arbiter ports.
package ysyx_23060072_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/ysyx_23060072_rr_arb2.sv
// Two-way round-robin chooser between the IFU (req[0]) and LSU (req[1]).
// Purely combinational; the parent owns and updates last_grant.
module ysyx_23060072_rr_arb2
  import ysyx_23060072_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output grant_e     grant
);

  // A lone requester wins; on a tie (or no request) favour whoever was not served last
  always_comb begin
    grant = GNT_IFU;
    case (req)
      2'b01:   grant = GNT_IFU;
      2'b10:   grant = GNT_LSU;
      default: grant = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
    endcase
  end

endmodule

// File: rtl/ysyx_23060072_mem_arbiter.sv
// Arbiter sharing one memory port between the instruction fetch unit and
// the load/store unit. One transaction is outstanding at a time; ties are
// broken round-robin. Optional watchdog enabled by defining
// YSYX_23060072_ARB_TIMEOUT_EN: a stuck transaction is closed with an
// error response after TIMEOUT_CYCLES cycles.
module ysyx_23060072_mem_arbiter
  import ysyx_23060072_pkg::*;
#(
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic                ifu_rsp_err,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic                lsu_rsp_err,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic                mem_rsp_err,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  state_e              state;
  grant_e              last_grant;
  grant_e              grant_id;
  grant_e              winner;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_wen;
  logic [DATA_W-1:0]   req_wdata;
  logic [MASK_W-1:0]   req_wmask;

  logic                hs_ifu;
  logic                hs_lsu;
  logic                rsp_fire;
  logic                rsp_err_n;
  logic [DATA_W-1:0]   rsp_data_n;

  ysyx_23060072_rr_arb2 u_rr_arb2 (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .grant      (winner)
  );

  // Only the arbitration winner sees ready, and only while no transaction is in flight
  always_comb begin
    ifu_req_ready = (state == IDLE) && (winner == GNT_IFU);
    lsu_req_ready = (state == IDLE) && (winner == GNT_LSU);
    hs_ifu        = ifu_req_valid && ifu_req_ready;
    hs_lsu        = lsu_req_valid && lsu_req_ready;
  end

  assign mem_req_valid = (state == REQ);
  assign mem_addr      = req_addr;
  assign mem_wen       = req_wen;
  assign mem_wdata     = req_wdata;
  assign mem_wmask     = req_wmask;

`ifdef YSYX_23060072_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wdog_cnt;
  logic             timeout_hit;

  // Watchdog counts cycles spent in REQ/WAIT_RSP and restarts whenever the FSM is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
    end else if (state == IDLE) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state != IDLE) && (wdog_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  wire unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Decide whether the outstanding transaction completes this cycle, and with what data
  always_comb begin
    rsp_fire   = 1'b0;
    rsp_err_n  = mem_rsp_err;
    rsp_data_n = mem_rdata;
    case (state)
      REQ:      rsp_fire = mem_req_ready && mem_rsp_valid;
      WAIT_RSP: rsp_fire = mem_rsp_valid;
      default:  rsp_fire = 1'b0;
    endcase
`ifdef YSYX_23060072_ARB_TIMEOUT_EN
    if (timeout_hit && !rsp_fire) begin
      rsp_fire   = 1'b1;
      rsp_err_n  = 1'b1;
      rsp_data_n = '0;
    end
`endif
  end

  // Arbiter FSM: accept a request, drive it to memory, return the response to its owner
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= GNT_LSU;
      grant_id      <= GNT_IFU;
      req_addr      <= '0;
      req_wen       <= 1'b0;
      req_wdata     <= '0;
      req_wmask     <= '0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_err   <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      lsu_rdata     <= '0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (hs_ifu) begin
            req_addr   <= ifu_addr;
            req_wen    <= 1'b0;
            req_wdata  <= '0;
            req_wmask  <= '0;
            grant_id   <= GNT_IFU;
            last_grant <= GNT_IFU;
            state      <= REQ;
          end else if (hs_lsu) begin
            req_addr   <= lsu_addr;
            req_wen    <= lsu_wen;
            req_wdata  <= lsu_wdata;
            req_wmask  <= lsu_wmask;
            grant_id   <= GNT_LSU;
            last_grant <= GNT_LSU;
            state      <= REQ;
          end
        end
        REQ, WAIT_RSP: begin
          if (rsp_fire) begin
            if (grant_id == GNT_IFU) begin
              ifu_rsp_valid <= 1'b1;
              ifu_rsp_err   <= rsp_err_n;
              ifu_rdata     <= rsp_data_n;
            end else begin
              lsu_rsp_valid <= 1'b1;
              lsu_rsp_err   <= rsp_err_n;
              lsu_rdata     <= rsp_data_n;
            end
            state <= IDLE;
          end else if ((state == REQ) && mem_req_ready) begin
            state <= WAIT_RSP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Directed self-checking bench for ysyx_23060072_mem_arbiter.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Timeout scenario runs only when YSYX_23060072_ARB_TIMEOUT_EN is defined.
module tb_ysyx_23060072_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int numCompared   = 0;
  int numMismatched = 0;

  ysyx_23060072_mem_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_err   (ifu_rsp_err),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_err   (lsu_rsp_err),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_err   (mem_rsp_err),
    .mem_rdata     (mem_rdata)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a scenario never returns
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic clearMem();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rdata     = 32'h0;
  endtask

  task automatic applyStimulus(input logic rspNow, input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    mem_rsp_valid = rspNow;
    mem_rsp_err   = 1'b0;
    mem_rdata     = rdata;
  endtask

  task automatic clearRequesters();
    ifu_req_valid = 1'b0;
    ifu_addr      = 32'h0;
    lsu_req_valid = 1'b0;
    lsu_addr      = 32'h0;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 4'h0;
  endtask

  initial begin
    logic [31:0] expAddr;
    logic        expIfu;
    int          seen;

    rst = 1'b1;
    clearRequesters();
    clearMem();
    nextCycle();
    nextCycle();

    // Reset state while reset is still held
    checkOutput("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'd0);
    checkOutput("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
    checkOutput("rst_ifu_rdata",     64'(ifu_rdata),     64'd0);
    checkOutput("rst_lsu_rdata",     64'(lsu_rdata),     64'd0);
    checkOutput("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_mem_addr",      64'(mem_addr),      64'd0);
    checkOutput("rst_ifu_ready",     64'(ifu_req_ready), 64'd1);
    checkOutput("rst_lsu_ready",     64'(lsu_req_ready), 64'd0);
    rst = 1'b0;

    // IFU-only fetch with immediate ready and same-cycle response
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    #1;
    checkOutput("ifu_only_ready", 64'(ifu_req_ready), 64'd1);
    nextCycle();
    ifu_req_valid = 1'b0;
    ifu_addr      = 32'h0;
    checkOutput("ifu_only_mem_valid", 64'(mem_req_valid), 64'd1);
    checkOutput("ifu_only_mem_addr",  64'(mem_addr),      64'h8000_0000);
    checkOutput("ifu_only_mem_wen",   64'(mem_wen),       64'd0);
    checkOutput("ifu_only_busy_rdy",  64'(ifu_req_ready), 64'd0);
    applyStimulus(1'b1, 32'h0000_0413);
    nextCycle();
    clearMem();
    checkOutput("ifu_only_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
    checkOutput("ifu_only_rdata",     64'(ifu_rdata),     64'h0000_0413);
    checkOutput("ifu_only_err",       64'(ifu_rsp_err),   64'd0);
    checkOutput("ifu_only_lsu_valid", 64'(lsu_rsp_valid), 64'd0);
    checkOutput("ifu_only_no_wait",   64'(mem_req_valid), 64'd0);
    nextCycle();
    checkOutput("ifu_only_pulse_end", 64'(ifu_rsp_valid), 64'd0);
    checkOutput("ifu_only_rdata_hold", 64'(ifu_rdata),    64'h0000_0413);

    // LSU store with three wait cycles before memory accepts
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'hF;
    #1;
    checkOutput("store_lsu_ready", 64'(lsu_req_ready), 64'd1);
    checkOutput("store_ifu_ready", 64'(ifu_req_ready), 64'd0);
    nextCycle();
    clearRequesters();
    for (int i = 0; i < 3; i++) begin
      checkOutput("store_wait_valid", 64'(mem_req_valid), 64'd1);
      checkOutput("store_wait_addr",  64'(mem_addr),      64'h8000_1000);
      checkOutput("store_wait_wen",   64'(mem_wen),       64'd1);
      checkOutput("store_wait_wdata", 64'(mem_wdata),     64'hDEAD_BEEF);
      checkOutput("store_wait_wmask", 64'(mem_wmask),     64'hF);
      nextCycle();
    end
    mem_req_ready = 1'b1;
    checkOutput("store_accept_addr", 64'(mem_addr), 64'h8000_1000);
    nextCycle();
    clearMem();
    checkOutput("store_waitrsp_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("store_waitrsp_norsp", 64'(lsu_rsp_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    nextCycle();
    clearMem();
    checkOutput("store_rsp_valid",  64'(lsu_rsp_valid), 64'd1);
    checkOutput("store_ifu_quiet",  64'(ifu_rsp_valid), 64'd0);
    checkOutput("store_ifu_hold",   64'(ifu_rdata),     64'h0000_0413);
    nextCycle();
    checkOutput("store_pulse_end",  64'(lsu_rsp_valid), 64'd0);

    // Both requesters valid from reset: grant order IFU, LSU, IFU, LSU
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h0000_0200;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0000_0100;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'h0000_00AA;
    lsu_wmask     = 4'h3;
    for (int k = 0; k < 4; k++) begin
      expIfu  = (k % 2 == 0);
      expAddr = expIfu ? 32'h0000_0200 : 32'h0000_0100;
      #1;
      checkOutput($sformatf("rr%0d_ifu_ready", k), 64'(ifu_req_ready), 64'(expIfu));
      checkOutput($sformatf("rr%0d_lsu_ready", k), 64'(lsu_req_ready), 64'(!expIfu));
      nextCycle();
      checkOutput($sformatf("rr%0d_mem_addr", k), 64'(mem_addr), 64'(expAddr));
      checkOutput($sformatf("rr%0d_mem_wen", k),  64'(mem_wen),  64'(!expIfu));
      checkOutput($sformatf("rr%0d_busy", k),     64'(ifu_req_ready | lsu_req_ready), 64'd0);
      applyStimulus(1'b1, 32'h0000_1000 + 32'(k));
      nextCycle();
      clearMem();
      checkOutput($sformatf("rr%0d_ifu_rsp", k), 64'(ifu_rsp_valid), 64'(expIfu));
      checkOutput($sformatf("rr%0d_lsu_rsp", k), 64'(lsu_rsp_valid), 64'(!expIfu));
      if (expIfu)
        checkOutput($sformatf("rr%0d_rdata", k), 64'(ifu_rdata), 64'(32'h0000_1000 + 32'(k)));
      else
        checkOutput($sformatf("rr%0d_rdata", k), 64'(lsu_rdata), 64'(32'h0000_1000 + 32'(k)));
    end
    clearRequesters();
    nextCycle();

    // Spurious memory response while idle is dropped
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0000_0BAD;
    nextCycle();
    clearMem();
    checkOutput("spurious_ifu_rsp",   64'(ifu_rsp_valid), 64'd0);
    checkOutput("spurious_lsu_rsp",   64'(lsu_rsp_valid), 64'd0);
    checkOutput("spurious_ifu_rdata", 64'(ifu_rdata),     64'h0000_1002);
    checkOutput("spurious_lsu_rdata", 64'(lsu_rdata),     64'h0000_1003);

    // Reset during WAIT_RSP aborts the transaction; the late response is dropped
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0040;
    nextCycle();
    clearRequesters();
    mem_req_ready = 1'b1;
    nextCycle();
    clearMem();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    nextCycle();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0000_0055;
    nextCycle();
    clearMem();
    checkOutput("abort_ifu_rsp",   64'(ifu_rsp_valid), 64'd0);
    checkOutput("abort_lsu_rsp",   64'(lsu_rsp_valid), 64'd0);
    checkOutput("abort_ifu_err",   64'(ifu_rsp_err),   64'd0);
    checkOutput("abort_ifu_rdata", 64'(ifu_rdata),     64'd0);
    checkOutput("abort_lsu_rdata", 64'(lsu_rdata),     64'd0);
    checkOutput("abort_mem_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("abort_mem_addr",  64'(mem_addr),      64'd0);
    checkOutput("abort_ifu_ready", 64'(ifu_req_ready), 64'd1);

`ifdef YSYX_23060072_ARB_TIMEOUT_EN
    // Memory never accepts: watchdog closes the fetch with an error after 16 cycles in REQ
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0010;
    nextCycle();
    clearRequesters();
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      if (ifu_rsp_valid) begin
        seen = i;
        break;
      end
      nextCycle();
    end
    checkOutput("timeout_latency", 64'(seen),        64'd17);
    checkOutput("timeout_err",     64'(ifu_rsp_err), 64'd1);
    checkOutput("timeout_rdata",   64'(ifu_rdata),   64'd0);
    checkOutput("timeout_idle",    64'(mem_req_valid), 64'd0);
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    nextCycle();
    clearRequesters();
    applyStimulus(1'b1, 32'h0000_0077);
    nextCycle();
    clearMem();
    checkOutput("after_timeout_rsp",   64'(lsu_rsp_valid), 64'd1);
    checkOutput("after_timeout_rdata", 64'(lsu_rdata),     64'h0000_0077);
    checkOutput("after_timeout_err",   64'(lsu_rsp_err),   64'd0);
`else
    seen = 0;
`endif

    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
